// File: rtl/vector_mul_pipe.sv
// Pipelined per-lane vector multiply / multiply-accumulate with element tags.
// Operands are conditioned and registered first. The 33x33 product follows, then delay stages, then the result/output register.
module vector_mul_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 3,
  parameter int TAG_W  = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             stall,
  input  logic             flush,
  input  logic [1:0]       sew,
  input  logic [1:0]       is_signed,
  input  logic             high_low,
  input  logic             mul_widen_ena,
  input  logic             multiply_type,
  input  logic             multiply_pos_neg,
  input  logic [TAG_W-1:0] tag_in,
  input  logic [XLEN-1:0]  vs1_data,
  input  logic [XLEN-1:0]  vs2_data,
  input  logic [XLEN-1:0]  vs3_data,
  output logic [XLEN-1:0]  wdata,
  output logic             done,
  output logic [TAG_W-1:0] tag_out,
  output logic             exception,
  output logic             busy,
  output logic             next_busy
);

  localparam int NS = STAGES - 1;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             exc;
    logic [1:0]       sew;
    logic             widen;
    logic             hl;
    logic             mt;
    logic             pn;
    logic [32:0]      a;
    logic [32:0]      b;
    logic [31:0]      vs3;
    logic [63:0]      prod;
  } stage_t;

  function automatic logic [32:0] cond_op(input logic [31:0] v, input logic [1:0] s,
                                          input logic sgn);
    case (s)
      2'b00:   return {{25{sgn & v[7]}}, v[7:0]};
      2'b01:   return {{17{sgn & v[15]}}, v[15:0]};
      default: return {sgn & v[31], v};
    endcase
  endfunction

  function automatic int unsigned sew_bits(input logic [1:0] s);
    case (s)
      2'b00:   return 8;
      2'b01:   return 16;
      default: return 32;
    endcase
  endfunction

  function automatic logic [63:0] low_mask(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

  // Accumulation wraps modulo 2^W; anything above W is forced to zero.
  function automatic logic [31:0] select_result(input stage_t s, input logic [63:0] p);
    int unsigned sw;
    int unsigned w;
    logic [63:0] r;
    sw = sew_bits(s.sew);
    w  = s.widen ? 2 * sw : sw;
    if (s.exc)
      r = '0;
    else if (s.mt)
      r = (s.pn ? ({32'd0, s.vs3} - p) : ({32'd0, s.vs3} + p)) & low_mask(w);
    else if (s.hl)
      r = (p >> sw) & low_mask(sw);
    else
      r = p & low_mask(w);
    return r[31:0];
  endfunction

  stage_t                stg_q [NS];
  stage_t                stg_d [NS];
  stage_t                last_s;
  logic [NS-1:0]         vld_q, vld_d;
  logic                  accept;
  logic signed [32:0]    mul_a, mul_b;
  logic signed [65:0]    mul_full;
  logic [63:0]           mul_prod;
  logic [XLEN-1:0]       wdata_q;
  logic                  done_q, exc_q;
  logic [TAG_W-1:0]      tag_q;

  assign accept = start & ~stall & ~flush;

  // Stage 0: operand conditioning
  always_comb begin
    stg_d[0].tag   = tag_in;
    stg_d[0].exc   = (sew == 2'b11) | (mul_widen_ena & (sew == 2'b10)) |
                     (mul_widen_ena & high_low & ~multiply_type);
    stg_d[0].sew   = sew;
    stg_d[0].widen = mul_widen_ena;
    stg_d[0].hl    = high_low;
    stg_d[0].mt    = multiply_type;
    stg_d[0].pn    = multiply_pos_neg;
    stg_d[0].a     = cond_op(vs2_data[31:0], sew, |is_signed);
    stg_d[0].b     = cond_op(vs1_data[31:0], sew, is_signed[1]);
    stg_d[0].vs3   = vs3_data[31:0];
    stg_d[0].prod  = '0;
    for (int k = 1; k < NS; k++) begin
      stg_d[k] = stg_q[k-1];
      if (k == 1) stg_d[k].prod = mul_prod;
    end
  end

  // Stage 1: signed product of the conditioned operands
  assign mul_a    = $signed(stg_q[0].a);
  assign mul_b    = $signed(stg_q[0].b);
  assign mul_full = mul_a * mul_b;
  assign mul_prod = mul_full[63:0];

  always_comb begin
    last_s      = stg_q[NS-1];
    last_s.prod = (NS == 1) ? mul_prod : stg_q[NS-1].prod;
  end

  always_comb begin
    vld_d[0] = accept;
    for (int k = 1; k < NS; k++) vld_d[k] = vld_q[k-1];
  end

  always_ff @(posedge CLK) begin
    if (!stall) begin
      for (int k = 0; k < NS; k++) stg_q[k] <= stg_d[k];
    end
  end

  // Final stage: result selection into the output register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_q   <= '0;
      done_q  <= 1'b0;
      wdata_q <= '0;
      tag_q   <= '0;
      exc_q   <= 1'b0;
    end else if (flush) begin
      vld_q  <= '0;
      done_q <= 1'b0;
    end else if (!stall) begin
      vld_q  <= vld_d;
      done_q <= vld_q[NS-1];
      if (vld_q[NS-1]) begin
        wdata_q <= XLEN'(select_result(last_s, last_s.prod));
        tag_q   <= last_s.tag;
        exc_q   <= last_s.exc;
      end
    end
  end

  assign wdata     = wdata_q;
  assign done      = done_q;
  assign tag_out   = tag_q;
  assign exception = exc_q;
  assign busy      = (|vld_q) | done_q;
  assign next_busy = flush ? 1'b0 : (stall ? busy : (accept | (|vld_q)));

endmodule

// File: tb/tb_vector_mul_pipe.sv
// Directed bench for vector_mul_pipe: arithmetic modes, latency, stall, flush, reset.
module tb_vector_mul_pipe;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 0, stall = 0, flush = 0;
  logic [1:0]  sew = 0, is_signed = 0;
  logic        high_low = 0, mul_widen_ena = 0, multiply_type = 0, multiply_pos_neg = 0;
  logic [4:0]  tag_in = 0;
  logic [31:0] vs1_data = 0, vs2_data = 0, vs3_data = 0;
  logic [31:0] wdata;
  logic        done;
  logic [4:0]  tag_out;
  logic        exception, busy, next_busy;

  int n_checks = 0;
  int n_errors = 0;

  vector_mul_pipe #(.XLEN(32), .STAGES(3), .TAG_W(5)) dut (
    .CLK(CLK), .RST(RST), .start(start), .stall(stall), .flush(flush),
    .sew(sew), .is_signed(is_signed), .high_low(high_low),
    .mul_widen_ena(mul_widen_ena), .multiply_type(multiply_type),
    .multiply_pos_neg(multiply_pos_neg), .tag_in(tag_in),
    .vs1_data(vs1_data), .vs2_data(vs2_data), .vs3_data(vs3_data),
    .wdata(wdata), .done(done), .tag_out(tag_out), .exception(exception),
    .busy(busy), .next_busy(next_busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_op(input logic [1:0] s, input logic [1:0] sg, input logic hl,
                        input logic wd, input logic mt, input logic pn, input logic [4:0] tg,
                        input logic [31:0] v3, input logic [31:0] v2, input logic [31:0] v1);
    start = 1; sew = s; is_signed = sg; high_low = hl; mul_widen_ena = wd;
    multiply_type = mt; multiply_pos_neg = pn; tag_in = tg;
    vs3_data = v3; vs2_data = v2; vs1_data = v1;
  endtask

  // Issue one op in the current cycle, expect done exactly three cycles later.
  task automatic do_op(input string nm, input logic [1:0] s, input logic [1:0] sg,
                       input logic hl, input logic wd, input logic mt, input logic pn,
                       input logic [31:0] v3, input logic [31:0] v2, input logic [31:0] v1,
                       input logic [31:0] exp, input logic exp_exc);
    set_op(s, sg, hl, wd, mt, pn, 5'd7, v3, v2, v1);
    next_cycle();
    start = 0;
    next_cycle();
    @(negedge CLK);
    chk({nm, "_early"}, {31'd0, done}, 32'd0);
    next_cycle();
    @(negedge CLK);
    chk({nm, "_done"}, {31'd0, done}, 32'd1);
    chk({nm, "_wdata"}, wdata, exp);
    chk({nm, "_exc"}, {31'd0, exception}, {31'd0, exp_exc});
    next_cycle();
  endtask

  int st_t  [9] = '{1, 1, 0, 0, 1, 0, 0, 0, 0};
  int sl_t  [9] = '{0, 0, 1, 1, 0, 0, 0, 0, 0};
  int tg_t  [9] = '{1, 2, 0, 0, 3, 0, 0, 0, 0};
  int dn_t  [9] = '{0, 0, 0, 0, 0, 1, 1, 1, 0};
  int to_t  [9] = '{0, 0, 0, 0, 0, 1, 2, 3, 0};
  int bz_t  [9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
  int nb_t  [9] = '{1, 1, 1, 1, 1, 1, 1, 0, 0};

  initial begin
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_tag", {27'd0, tag_out}, 32'd0);
    chk("rst_exc", {31'd0, exception}, 32'd0);
    chk("rst_busy", {30'd0, busy, next_busy}, 32'd0);
    RST = 0;
    next_cycle();

    do_op("ss32_lo",  2'b10, 2'b10, 0, 0, 0, 0, 0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 0);
    do_op("ss32_hi",  2'b10, 2'b10, 1, 0, 0, 0, 0, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 0);
    do_op("uu8_lo",   2'b00, 2'b00, 0, 0, 0, 0, 0, 32'hFF, 32'hFF, 32'h00000001, 0);
    do_op("uu8_hi",   2'b00, 2'b00, 1, 0, 0, 0, 0, 32'hFF, 32'hFF, 32'h000000FE, 0);
    do_op("ss8_hi",   2'b00, 2'b10, 1, 0, 0, 0, 0, 32'hFF, 32'hFF, 32'h00000000, 0);
    do_op("su16_wd",  2'b01, 2'b01, 0, 1, 0, 0, 0, 32'hFFFF, 32'hFFFF, 32'hFFFF0001, 0);
    do_op("mac_pos",  2'b10, 2'b10, 0, 0, 1, 0, 32'd100, 32'd7, 32'd6, 32'd142, 0);
    do_op("mac_neg",  2'b10, 2'b10, 0, 0, 1, 1, 32'd100, 32'd7, 32'd6, 32'd58, 0);
    do_op("mac_wrap", 2'b10, 2'b10, 0, 0, 1, 1, 32'd0, 32'd1, 32'd1, 32'hFFFFFFFF, 0);
    do_op("sew11",    2'b11, 2'b10, 0, 0, 0, 0, 0, 32'd3, 32'd5, 32'd0, 1);
    do_op("wd_sew32", 2'b10, 2'b00, 0, 1, 0, 0, 0, 32'd3, 32'd5, 32'd0, 1);
    do_op("uu8_trunc", 2'b00, 2'b00, 0, 0, 0, 0, 0, 32'h1234_5610, 32'hABCD_EF03, 32'h00000030, 0);

    // Stall sequence: tags 1,2 issued, two stall cycles, then tag 3.
    for (int c = 0; c < 9; c++) begin
      start = st_t[c][0];
      stall = sl_t[c][0];
      if (st_t[c] != 0) set_op(2'b10, 2'b10, 0, 0, 0, 0, 5'(tg_t[c]), 0, 32'(tg_t[c]), 32'd3);
      @(negedge CLK);
      chk($sformatf("stl_done_c%0d", c), {31'd0, done}, 32'(dn_t[c]));
      chk($sformatf("stl_busy_c%0d", c), {31'd0, busy}, 32'(bz_t[c]));
      chk($sformatf("stl_nbusy_c%0d", c), {31'd0, next_busy}, 32'(nb_t[c]));
      if (dn_t[c] != 0) begin
        chk($sformatf("stl_tag_c%0d", c), {27'd0, tag_out}, 32'(to_t[c]));
        chk($sformatf("stl_wdata_c%0d", c), wdata, 32'(to_t[c] * 3));
      end
      next_cycle();
    end
    start = 0; stall = 0;

    // Flush with two ops in flight, then a fresh op right after.
    set_op(2'b10, 2'b00, 0, 0, 0, 0, 5'd10, 0, 32'd11, 32'd2);
    next_cycle();
    set_op(2'b10, 2'b00, 0, 0, 0, 0, 5'd11, 0, 32'd12, 32'd2);
    next_cycle();
    start = 0; flush = 1;
    @(negedge CLK);
    chk("fl_busy_pre", {31'd0, busy}, 32'd1);
    chk("fl_nbusy", {31'd0, next_busy}, 32'd0);
    next_cycle();
    flush = 0;
    set_op(2'b10, 2'b00, 0, 0, 0, 0, 5'd12, 0, 32'd9, 32'd9);
    @(negedge CLK);
    chk("fl_busy_post", {31'd0, busy}, 32'd0);
    chk("fl_done_c3", {31'd0, done}, 32'd0);
    next_cycle();
    start = 0;
    for (int c = 4; c < 6; c++) begin
      @(negedge CLK);
      chk($sformatf("fl_done_c%0d", c), {31'd0, done}, 32'd0);
      next_cycle();
    end
    @(negedge CLK);
    chk("fl_new_done", {31'd0, done}, 32'd1);
    chk("fl_new_tag", {27'd0, tag_out}, 32'd12);
    chk("fl_new_wdata", wdata, 32'd81);
    next_cycle();

    // Asynchronous reset mid-flight.
    set_op(2'b10, 2'b00, 0, 0, 0, 0, 5'd13, 0, 32'd4, 32'd4);
    next_cycle();
    start = 0;
    #1 RST = 1;
    #1;
    chk("ar_wdata", wdata, 32'd0);
    chk("ar_tag", {27'd0, tag_out}, 32'd0);
    chk("ar_busy", {31'd0, busy}, 32'd0);
    @(negedge CLK);
    RST = 0;
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      @(negedge CLK);
      chk($sformatf("ar_done_%0d", c), {31'd0, done}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
